dcache_controller: RTL and testbench



---
 rtl/cache_pkg.sv | 14 +
 rtl/dcache_sram.sv | 45 ++++
 rtl/dcache_controller.sv | 110 +++++++++++
 tb/tb_dcache_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: geometry, address-field positions and FSM states for the L1 data cache.
package cache_pkg;
    localparam int LINES     = 32;
    localparam int LINE_BITS = 256;
    localparam int ADDR_W    = 32;
    localparam int INDEX_W   = $clog2(LINES);
    localparam int OFFSET_W  = 5;
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORD_LSB  = 2;
    localparam int TAG_LSB   = OFFSET_W + INDEX_W;
    typedef enum logic [2:0] {
        S_IDLE, S_MISS, S_WRITEBACK, S_REFILL, S_REFILL_DONE
    } state_t;
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: per-line valid/dirty/tag/data storage, one async read port and one write port.
module dcache_sram
    import cache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [INDEX_W-1:0]   i_rd_idx,
    output logic                 o_rd_valid,
    output logic                 o_rd_dirty,
    output logic [TAG_W-1:0]     o_rd_tag,
    output logic [LINE_BITS-1:0] o_rd_data,
    input  logic                 i_we,
    input  logic [INDEX_W-1:0]   i_wr_idx,
    input  logic                 i_wr_valid,
    input  logic                 i_wr_dirty,
    input  logic [TAG_W-1:0]     i_wr_tag,
    input  logic [LINE_BITS-1:0] i_wr_data
);
    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;
    logic [TAG_W-1:0]     r_tag  [LINES];
    logic [LINE_BITS-1:0] r_data [LINES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= i_wr_valid;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate L1 D-cache with a line-wide
// one-outstanding memory handshake and a combinational pipeline stall.
module dcache_controller
    import cache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic [31:0]          p1_data_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);
    state_t               r_state, w_next;
    logic                 r_mem_en;
    logic [TAG_W-1:0]     r_tag;
    logic [INDEX_W-1:0]   r_idx;
    logic [LINE_BITS-1:0] r_line;
    logic                 w_req, w_hit, w_ack, w_fill, w_we;
    logic [TAG_W-1:0]     w_p1_tag, w_rd_tag, w_wr_tag;
    logic [INDEX_W-1:0]   w_p1_idx, w_idx;
    logic [2:0]           w_word;
    logic [7:0]           w_shift;
    logic                 w_rd_valid, w_rd_dirty;
    logic [LINE_BITS-1:0] w_rd_data, w_merged, w_wr_data;
    logic                 w_unused;

    assign w_p1_tag = p1_addr_i[ADDR_W-1:TAG_LSB];
    assign w_p1_idx = p1_addr_i[TAG_LSB-1:OFFSET_W];
    assign w_word   = p1_addr_i[OFFSET_W-1:WORD_LSB];
    assign w_unused = ^p1_addr_i[WORD_LSB-1:0];
    assign w_shift  = {w_word, 5'b0};
    assign w_req    = p1_MemRead_i | p1_MemWrite_i;
    assign w_idx    = (r_state == S_IDLE) ? w_p1_idx : r_idx;
    assign w_hit    = w_req & (r_state == S_IDLE) & w_rd_valid & (w_rd_tag == w_p1_tag);
    assign w_ack    = mem_ack_i & r_mem_en;
    assign w_fill   = (r_state == S_REFILL_DONE);
    assign w_we     = w_fill | (w_hit & p1_MemWrite_i);
    assign w_merged = (w_rd_data & ~(LINE_BITS'(32'hFFFF_FFFF) << w_shift))
                    | (LINE_BITS'(p1_data_i) << w_shift);
    assign w_wr_tag  = w_fill ? r_tag : w_rd_tag;
    assign w_wr_data = w_fill ? r_line : w_merged;

    assign p1_stall_o = w_req & ~w_hit;
    assign p1_data_o  = (w_hit & ~p1_MemWrite_i) ? w_rd_data[w_shift +: 32] : 32'h0;

    dcache_sram u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_dirty (w_rd_dirty),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_we),
        .i_wr_idx   (w_idx),
        .i_wr_valid (1'b1),
        .i_wr_dirty (~w_fill),
        .i_wr_tag   (w_wr_tag),
        .i_wr_data  (w_wr_data)
    );

    // Enable drops for one cycle after every ack, so the refill following a
    // write-back is seen by memory as a fresh request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_mem_en <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_mem_en <= ((w_next == S_WRITEBACK) | (w_next == S_REFILL)) & ~w_ack;
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_state == S_IDLE && w_next == S_MISS) begin
            r_tag <= w_p1_tag;
            r_idx <= w_p1_idx;
        end
        if (r_state == S_REFILL && w_ack) r_line <= mem_data_i;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:        if (w_req & ~w_hit) w_next = S_MISS;
            S_MISS:        w_next = (w_rd_valid & w_rd_dirty) ? S_WRITEBACK : S_REFILL;
            S_WRITEBACK:   if (w_ack) w_next = S_REFILL;
            S_REFILL:      if (w_ack) w_next = S_REFILL_DONE;
            S_REFILL_DONE: w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = r_mem_en;
        mem_write_o  = (r_state == S_WRITEBACK);
        mem_addr_o   = (r_state == S_WRITEBACK) ? {w_rd_tag, r_idx, {OFFSET_W{1'b0}}}
                     : (r_state == S_REFILL)    ? {r_tag, r_idx, {OFFSET_W{1'b0}}}
                     : '0;
        mem_data_o   = (r_state == S_WRITEBACK) ? w_rd_data : '0;
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed bench with a fixed-latency line memory whose word k of
// line A holds 0xA500_0000 | (A + 4k).
module tb_dcache_controller;
    import cache_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 p1_MemRead_i, p1_MemWrite_i;
    logic [ADDR_W-1:0]    p1_addr_i;
    logic [31:0]          p1_data_i, p1_data_o;
    logic                 p1_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_o, mem_data_i;

    int checks = 0;
    int errors = 0;
    int n_rd = 0;
    int n_wr = 0;
    int cnt = 0;
    localparam int LAT = 10;
    logic [31:0]          rd_addr = '0, wb_addr = '0;
    logic [LINE_BITS-1:0] wb_data = '0;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [LINE_BITS-1:0] pat(input logic [31:0] a);
        logic [LINE_BITS-1:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'hA500_0000 | (a + 32'(4*k));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [LINE_BITS-1:0] got, input logic [LINE_BITS-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int stalls);
        @(negedge clk_i);
        p1_MemRead_i = rd; p1_MemWrite_i = wr; p1_addr_i = a; p1_data_i = d;
        #1;
        stalls = 0;
        while (p1_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk_i);
            #1;
        end
    endtask

    // Ack on the LAT-th consecutive cycle of mem_enable_o.
    initial begin
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_enable_o) begin
                cnt++;
                if (cnt == LAT) begin
                    mem_ack_i = 1'b1;
                    cnt = 0;
                    if (mem_write_o) begin
                        n_wr++; wb_addr = mem_addr_o; wb_data = mem_data_o;
                    end else begin
                        n_rd++; rd_addr = mem_addr_o; mem_data_i = pat(mem_addr_o);
                    end
                end else mem_ack_i = 1'b0;
            end else begin
                mem_ack_i = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int w;
        logic [31:0] a;
        logic [LINE_BITS-1:0] e;
        rst_i = 1'b1; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_enable", mem_enable_o, 0);
        chk("reset_stall", p1_stall_o, 0);
        chk("reset_data", p1_data_o, 0);
        chk("reset_addr", mem_addr_o, 0);
        rst_i = 1'b0;

        access(1, 0, 32'h40, 0, s);
        chk("cold_stall", s, 13);
        chk("cold_data", p1_data_o, 32'hA500_0040);
        chk("cold_nrd", n_rd, 1);
        chk("cold_rdaddr", rd_addr, 32'h40);
        chk("cold_nwr", n_wr, 0);

        for (int i = 0; i < 6; i++) begin
            a = (i % 2 == 1) ? 32'h5C : 32'h40;
            access(1, 0, a, 0, s);
            chk("b2b_stall", s, 0);
            chk("b2b_data", p1_data_o, 32'hA500_0000 | a);
        end
        chk("b2b_nrd", n_rd, 1);

        access(0, 1, 32'h44, 32'hDEAD_BEEF, s);
        chk("store_stall", s, 0);
        access(1, 0, 32'h44, 0, s);
        chk("load44_stall", s, 0);
        chk("load44_data", p1_data_o, 32'hDEAD_BEEF);
        chk("dirty2_set", dut.u_sram.r_dirty[2], 1);

        access(1, 0, 32'h444, 0, s);
        e = pat(32'h40);
        e[63:32] = 32'hDEAD_BEEF;
        chk("dirty_stall", s, 24);
        chk("dirty_nwr", n_wr, 1);
        chk("wb_addr", wb_addr, 32'h40);
        chk("wb_data", wb_data, e);
        chk("dirty_nrd", n_rd, 2);
        chk("dirty_rdaddr", rd_addr, 32'h440);
        chk("dirty_data", p1_data_o, 32'hA500_0444);
        chk("dirty2_clear", dut.u_sram.r_dirty[2], 0);

        access(1, 0, 32'h844, 0, s);
        chk("clean_stall", s, 13);
        chk("clean_nwr", n_wr, 1);
        chk("clean_nrd", n_rd, 3);
        chk("clean_rdaddr", rd_addr, 32'h840);
        chk("clean_data", p1_data_o, 32'hA500_0844);

        @(negedge clk_i);
        p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0; p1_addr_i = 32'hC0;
        w = 0;
        while (!mem_enable_o && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        chk("rstmid_enabled", mem_enable_o, 1);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        p1_MemRead_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("rstmid_enable_off", mem_enable_o, 0);
        chk("rstmid_valid_clr", dut.u_sram.r_valid, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rstmid_nrd", n_rd, 3);

        access(1, 0, 32'hC0, 0, s);
        chk("after_rst_stall", s, 13);
        chk("after_rst_data", p1_data_o, 32'hA500_00C0);
        access(1, 0, 32'h844, 0, s);
        chk("after_rst_remiss", s, 13);
        chk("after_rst_nrd", n_rd, 5);

        @(negedge clk_i);
        p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        #1;
        chk("idle_data_zero", p1_data_o, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
